// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetcher: owns the PC, fetches one word at a time and holds it for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-redirect trap and a HALT state.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'hBFC00000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [6:0]            op,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic                  stall,
    input  logic                  pc_src,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [31:0]           retire_cnt
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    assign imem_addr   = pc;
    assign pc_plus4    = pc + ADDR_WIDTH'(4);
    assign redirect_pc = {target[ADDR_WIDTH-1:2], 2'b00};

    assign op     = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

`ifndef FETCH_MISALIGN_TRAP_EN
    // Low target bits are dropped by the redirect when there is no trap to report them.
    logic unused_target_lsb;
    assign unused_target_lsb = ^target[1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= NOP;
            retire_cnt  <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        state       <= ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    // stall has priority; pc_src is only looked at on the retire edge
                    if (!stall) begin
                        retire_cnt  <= retire_cnt + 32'd1;
                        instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (pc_src && (target[1:0] != 2'b00)) begin
                            misalign_err <= 1'b1;
                            pc           <= target;
                            state        <= HALT;
                        end else begin
                            pc       <= pc_src ? redirect_pc : pc_plus4;
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
`else
                        pc       <= pc_src ? redirect_pc : pc_plus4;
                        state    <= FETCH;
                        imem_req <= 1'b1;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
`endif
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed test-plan scenarios plus randomized traffic,
// all cycles checked against a transaction-level model of the fetch/issue/retire rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc_plus4;
    logic        stall, pc_src;
    logic [31:0] target;
    logic [31:0] retire_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr),
        .op(op), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .pc(pc), .pc_plus4(pc_plus4),
        .stall(stall), .pc_src(pc_src), .target(target),
        .retire_cnt(retire_cnt)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: where the fetcher is in its fetch/issue cycle, and the architectural state.
    localparam int M_IDLE = 0, M_WAIT_MEM = 1, M_HOLD = 2, M_HALTED = 3;
    int          m_where;
    logic [31:0] m_pc, m_instr, m_cnt;
    logic        m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_where <= M_IDLE;
            m_pc    <= 32'hBFC00000;
            m_instr <= 32'h00000013;
            m_cnt   <= 0;
            m_err   <= 1'b0;
        end else if (m_where == M_IDLE) begin
            m_where <= M_WAIT_MEM;
        end else if (m_where == M_WAIT_MEM && imem_ready) begin
            m_instr <= imem_rdata;
            m_where <= M_HOLD;
        end else if (m_where == M_HOLD && !stall) begin
            m_cnt <= m_cnt + 1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_src && (target % 4 != 0)) begin
                m_err   <= 1'b1;
                m_pc    <= target;
                m_where <= M_HALTED;
            end else begin
                m_pc    <= pc_src ? (target & ~32'd3) : m_pc + 32'd4;
                m_where <= M_WAIT_MEM;
            end
`else
            m_pc    <= pc_src ? (target & ~32'd3) : m_pc + 32'd4;
            m_where <= M_WAIT_MEM;
`endif
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("imem_req", imem_req, m_where == M_WAIT_MEM);
            if (m_where == M_WAIT_MEM) chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", instr_valid, m_where == M_HOLD);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, 32'(m_pc + 32'd4));
            chk("instr", instr, m_instr);
            chk("fields", {funct7, rs2, rs1, funct3, rd, op},
                {m_instr[31:25], m_instr[24:20], m_instr[19:15], m_instr[14:12], m_instr[11:7], m_instr[6:0]});
            chk("retire_cnt", retire_cnt, m_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("misalign_err", misalign_err, m_err);
`endif
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'hBFC00000);
        chk({tag, "_instr"}, instr, 32'h00000013);
        chk({tag, "_cnt"}, retire_cnt, 0);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_valid"}, instr_valid, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, "_err"}, misalign_err, 0);
`endif
    endtask

    logic [31:0] addrs[$];

    initial begin
        rst = 1'b1; imem_ready = 0; imem_rdata = 0; stall = 0; pc_src = 0; target = 0;
        #3 chk_reset_vals("rst0");
        @(negedge clk); rst = 1'b0;

        // Straight-line fetch with memory always ready
        imem_ready = 1; imem_rdata = 32'h00500093;
        repeat (7) begin
            @(negedge clk);
            if (imem_req) addrs.push_back(imem_addr);
        end
        chk("seq_n", addrs.size(), 4);
        if (addrs.size() >= 3) begin
            chk("seq_a0", addrs[0], 32'hBFC00000);
            chk("seq_a1", addrs[1], 32'hBFC00004);
            chk("seq_a2", addrs[2], 32'hBFC00008);
        end
        chk("seq_cnt", retire_cnt, 3);
        chk("seq_op", op, 7'h13);
        chk("seq_rd", rd, 1);
        chk("seq_f3", funct3, 0);

        // Memory wait states in FETCH
        imem_ready = 0;
        repeat (4) begin
            @(negedge clk);
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, 32'hBFC0000C);
            chk("wait_valid", instr_valid, 0);
        end
        imem_ready = 1;
        @(negedge clk);
        chk("wait_issue", instr_valid, 1);

        // Stall with a pending redirect that is withdrawn before retire
        imem_ready = 0; imem_rdata = 32'hDEADBEEF;
        stall = 1; pc_src = 1; target = 32'h100;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", instr_valid, 1);
            chk("stall_pc", pc, 32'hBFC0000C);
            chk("stall_instr", instr, 32'h00500093);
        end
        stall = 0; pc_src = 0;
        @(negedge clk);
        chk("stall_next", imem_addr, 32'hBFC00010);

        // PC wrap at the top of the address space
        imem_ready = 1;
        @(negedge clk);
        pc_src = 1; target = 32'hFFFFFFFC;
        @(negedge clk);
        chk("wrap_fetch", imem_addr, 32'hFFFFFFFC);
        pc_src = 0;
        @(negedge clk);
        chk("wrap_pc4", pc_plus4, 32'h0);
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'h0);
        @(negedge clk);

        // Misaligned redirect
        pc_src = 1; target = 32'h00000203;
        @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_err", misalign_err, 1);
        chk("mis_req", imem_req, 0);
        chk("mis_valid", instr_valid, 0);
        @(negedge clk);
        chk("halt_req", imem_req, 0);
        chk("halt_pc", pc, 32'h00000203);
`else
        chk("mis_addr", imem_addr, 32'h00000200);
        chk("mis_req", imem_req, 1);
`endif
        pc_src = 0;

        // Async reset in the middle of a fetch
        imem_ready = 0;
        rst = 1;
        @(negedge clk); rst = 0;
        @(negedge clk);
        imem_ready = 1;
        @(negedge clk);
        @(negedge clk);
        imem_ready = 0;
        @(negedge clk);
        chk("pre_rst_cnt", retire_cnt, 1);
        @(posedge clk);
        #2 rst = 1;
        #1 chk_reset_vals("async");
        #1 rst = 0;
        @(negedge clk);
        chk("rel_req0", imem_req, 0);
        @(negedge clk);
        chk("rel_req1", imem_req, 1);
        chk("rel_addr", imem_addr, 32'hBFC00000);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            imem_ready = ($urandom_range(0, 9) < 7);
            imem_rdata = $urandom;
            stall      = ($urandom_range(0, 9) < 3);
            pc_src     = ($urandom_range(0, 9) < 2);
            target     = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            if ($urandom_range(0, 39) != 0) target[1:0] = 2'b00;
`endif
            if (i % 300 == 299) begin
                #2 rst = 1;
                #1 rst = 0;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential instruction fetcher: the producing end of the control unit's decode interface.
- Owns the PC and fetches 32-bit words from instruction memory over a req/ready handshake.
- Presents one instruction at a time as op/funct3/funct7/rs1/rs2/rd, and consumes the branch/jump decision (pc_src, target) back from the control path.
- Single-issue, non-pipelined: one instruction in flight.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory address.
- RESET_PC, 32'hBFC00000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  ADDR_WIDTH  fetch address, equal to pc.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  decode fields valid; high only in ISSUE.
- instr  out  32  held instruction word.
- op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- rs1, rs2, rd  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- pc  out  ADDR_WIDTH  address of held instruction.
- pc_plus4  out  ADDR_WIDTH  pc+4, modulo 2^ADDR_WIDTH.
- stall  in  1  downstream not ready; holds ISSUE.
- pc_src  in  1  take redirect on retire.
- target  in  ADDR_WIDTH  redirect address.
- retire_cnt  out  32  count of retired instructions.

Behaviour:
- States: IDLE, FETCH, ISSUE. An async assert of rst forces IDLE from any state, including mid-fetch.
- Reset values:
  - pc=RESET_PC, instr=32'h00000013 (NOP), retire_cnt=0.
  - imem_req=0, instr_valid=0.
- IDLE: imem_req=0. Next edge goes to FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Waits any number of cycles for imem_ready.
  - On imem_ready: instr<=imem_rdata, go to ISSUE.
  - stall and pc_src are ignored in this state.
- ISSUE:
  - instr_valid=1; fields are a combinational slice of the instr register.
  - While stall=1: hold pc/instr, ignore pc_src/target.
  - Retire condition is stall=0. On that edge:
    - retire_cnt += 1.
    - pc <= pc_src ? {target[ADDR_WIDTH-1:2],2'b00} : pc+4.
    - Go to FETCH.
  - imem_ready in ISSUE is ignored.
- Latency: with imem_ready high in the FETCH cycle, an instruction is fetched and retired in 2 cycles (FETCH, ISSUE). Each cycle of imem_ready delay or stall adds one cycle.
- Wrap-around:
  - pc+4 wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000).
  - retire_cnt wraps 0xFFFFFFFF -> 0.
- Redirect to the current pc is legal: the same address is refetched.
- Simultaneous stall=1 and pc_src=1: stall wins; pc_src is re-sampled on the retire edge.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output misalign_err (1 bit, reset 0) and state HALT.
  - If target[1:0]!=0 on a retire with pc_src=1: misalign_err<=1 (sticky), pc<=target unmodified, go to HALT.
  - HALT: imem_req=0, instr_valid=0; exited only by rst.
  - retire_cnt still increments for the trapping instruction.
- Disabled: no extra port or state; target[1:0] is silently cleared.

Test Plan:
- Reset release, imem_ready=1 every cycle, rdata=32'h00500093, stall=0, pc_src=0:
  - imem_addr sequence is BFC00000, BFC00004, BFC00008.
  - op=7'h13, rd=1, funct3=0.
  - retire_cnt=3 after 6 FETCH/ISSUE cycles.
- imem_ready held low 4 cycles in FETCH: imem_req stays 1, addr stable, instr_valid=0. ISSUE is entered on the edge after ready.
- In ISSUE, stall=1 for 3 cycles with pc_src=1, target=0x100, then stall=0 with pc_src=0:
  - pc and instr are held during the stall.
  - Next fetch addr is pc+4; the redirect is not taken.
- Retire with pc_src=1, target=0x00000203:
  - Disabled build: next imem_addr=0x00000200.
  - Enabled build: misalign_err=1, HALT, imem_req=0.
- pc=0xFFFFFFFC retires with pc_src=0: next imem_addr=0x00000000, pc_plus4 wraps correctly.
- Async rst pulse mid-FETCH with imem_ready=0:
  - Outputs return to reset values immediately, without a clock edge.
  - Fetch resumes at BFC00000 one cycle after release.
